// File: rtl/hex_display_scanner.sv
// hex_display_scanner: time-multiplexed hex driver for a common-anode 7-seg bank.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 always lit).
module hex_display_scanner #(
  parameter  int NUM_DIGITS  = 4,
  parameter  int REFRESH_DIV = 50000,
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int VAL_W = 4 * NUM_DIGITS
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [VAL_W-1:0]      value,
  input  logic                  load,
  input  logic                  display_en,
  output logic [3:0]            nibble,
  output logic [NUM_DIGITS-1:0] anode_n,
  output logic [IDX_W-1:0]      digit_idx
);

  localparam int CNT_W = $clog2(REFRESH_DIV);

  logic [CNT_W-1:0]      cnt;
  logic                  tc;
  logic                  last;
  logic [VAL_W-1:0]      shadow;
  logic [3:0]            cur_nib;
  logic [NUM_DIGITS-1:0] cur_sel;
  logic                  blank;

  assign tc   = (cnt == CNT_W'(REFRESH_DIV - 1));
  assign last = (digit_idx == IDX_W'(NUM_DIGITS - 1));

  always_ff @(posedge clk) begin
    if (!reset_n)
      cnt <= '0;
    else if (tc)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      digit_idx <= '0;
    else if (tc)
      digit_idx <= last ? '0 : digit_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      shadow <= '0;
    else if (load)
      shadow <= value;
  end

  always_comb begin
    cur_nib = 4'h0;
    cur_sel = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (digit_idx == IDX_W'(k)) begin
        cur_nib    = shadow[4*k +: 4];
        cur_sel[k] = 1'b1;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // lead_zero[k]: nibbles k..top are all zero; bit 0 stays clear
  logic [NUM_DIGITS-1:0] lead_zero;

  always_comb begin
    lead_zero = '0;
    for (int k = 1; k < NUM_DIGITS; k++)
      lead_zero[k] = ((shadow >> (4*k)) == '0);
  end

  assign blank = |(cur_sel & lead_zero);
`else
  assign blank = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      nibble  <= 4'h0;
      anode_n <= '1;
    end else begin
      nibble  <= cur_nib;
      anode_n <= (display_en && !blank) ? ~cur_sel : '1;
    end
  end

endmodule

// File: tb/tb_hex_display_scanner.sv
// tb_hex_display_scanner: directed and random checks of hex_display_scanner
// against a tick-count reference model (NUM_DIGITS=4, REFRESH_DIV=4).
module tb_hex_display_scanner;

  localparam int ND  = 4;
  localparam int DIV = 4;

  logic        clk;
  logic        reset_n;
  logic [15:0] value;
  logic        load;
  logic        display_en;
  logic [3:0]  nibble;
  logic [3:0]  anode_n;
  logic [1:0]  digit_idx;

  int checks = 0;
  int errors = 0;

  hex_display_scanner #(
    .NUM_DIGITS (ND),
    .REFRESH_DIV(DIV)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .value     (value),
    .load      (load),
    .display_en(display_en),
    .nibble    (nibble),
    .anode_n   (anode_n),
    .digit_idx (digit_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: selected digit is floor(ticks/DIV) mod ND,
  // ticks = rising edges since reset was released.
  int          m_ticks;
  logic [15:0] m_shadow;
  logic [3:0]  exp_nibble;
  logic [3:0]  exp_anode;
  int          exp_idx;
  int          cur_idx;

  assign cur_idx = (m_ticks / DIV) % ND;

  function automatic bit model_blank(logic [15:0] sh, int d);
    bit lz;
    bit en;
    lz = (d != 0) && ((sh >> (4*d)) == 16'h0);
`ifdef LEADING_ZERO_BLANK_EN
    en = 1'b1;
`else
    en = 1'b0;
`endif
    return en && lz;
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      m_ticks    <= 0;
      m_shadow   <= 16'h0;
      exp_nibble <= 4'h0;
      exp_anode  <= 4'hF;
      exp_idx    <= 0;
    end else begin
      exp_nibble <= 4'(m_shadow >> (4*cur_idx));
      exp_anode  <= (display_en && !model_blank(m_shadow, cur_idx))
                    ? ~(4'b1 << cur_idx) : 4'hF;
      if (load)
        m_shadow <= value;
      m_ticks <= m_ticks + 1;
      exp_idx <= ((m_ticks + 1) / DIV) % ND;
    end
  end

  task automatic test_reset();
    display_en = 1'b1;
    load       = 1'b0;
    value      = 16'h0;
    reset_n    = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (anode_n !== 4'hF) begin
      errors++;
      $display("FAIL reset_anode got %b want 1111", anode_n);
    end
    checks++;
    if (nibble !== 4'h0) begin
      errors++;
      $display("FAIL reset_nibble got %h want 0", nibble);
    end
    checks++;
    if (digit_idx !== 2'd0) begin
      errors++;
      $display("FAIL reset_idx got %0d want 0", digit_idx);
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (anode_n !== 4'b1110) begin
      errors++;
      $display("FAIL release_anode got %b want 1110", anode_n);
    end
    checks++;
    if (nibble !== 4'h0) begin
      errors++;
      $display("FAIL release_nibble got %h want 0", nibble);
    end
  endtask

  task automatic test_scan();
    logic [15:0] v;
    int d;
    logic [3:0] en;
    logic [3:0] ea;
    v = 16'h3A7F;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    load    = 1'b1;
    value   = v;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1)
        load = 1'b0;
      checks++;
      if (nibble !== exp_nibble || anode_n !== exp_anode) begin
        errors++;
        $display("FAIL scan_model n=%0d got %h/%b want %h/%b",
                 n, nibble, anode_n, exp_nibble, exp_anode);
      end
      if (n >= 5) begin
        d  = (1 + (n - 5) / DIV) % ND;
        en = 4'(v >> (4*d));
        ea = ~(4'b1 << d);
        checks++;
        if (nibble !== en || anode_n !== ea) begin
          errors++;
          $display("FAIL scan_seq n=%0d got %h/%b want %h/%b",
                   n, nibble, anode_n, en, ea);
        end
      end
    end
  endtask

  task automatic test_load_on_tc();
    bit found;
    int old_d;
    int new_d;
    logic [15:0] old_sh;
    logic [15:0] nv;
    nv = 16'h1234;
    found = 1'b0;
    for (int i = 0; i < 2*DIV; i++) begin
      if (m_ticks % DIV == DIV - 1) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL tc_wait got timeout want terminal count");
    end
    old_d  = (m_ticks / DIV) % ND;
    new_d  = (old_d + 1) % ND;
    old_sh = m_shadow;
    load   = 1'b1;
    value  = nv;
    @(negedge clk);
    load = 1'b0;
    checks++;
    if (anode_n !== ~(4'b1 << old_d) ||
        nibble !== 4'(old_sh >> (4*old_d))) begin
      errors++;
      $display("FAIL tc_old got %h/%b want %h/%b", nibble, anode_n,
               4'(old_sh >> (4*old_d)), ~(4'b1 << old_d));
    end
    @(negedge clk);
    checks++;
    if (anode_n !== ~(4'b1 << new_d) ||
        nibble !== 4'(nv >> (4*new_d))) begin
      errors++;
      $display("FAIL tc_new got %h/%b want %h/%b", nibble, anode_n,
               4'(nv >> (4*new_d)), ~(4'b1 << new_d));
    end
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (nibble !== exp_nibble || anode_n !== exp_anode) begin
        errors++;
        $display("FAIL tc_model got %h/%b want %h/%b",
                 nibble, anode_n, exp_nibble, exp_anode);
      end
    end
  endtask

  task automatic test_display_en();
    repeat (2) @(negedge clk);
    display_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (anode_n !== 4'hF) begin
        errors++;
        $display("FAIL dis_anode i=%0d got %b want 1111", i, anode_n);
      end
      checks++;
      if (digit_idx !== 2'(exp_idx) || nibble !== exp_nibble) begin
        errors++;
        $display("FAIL dis_track i=%0d got %0d/%h want %0d/%h",
                 i, digit_idx, nibble, exp_idx, exp_nibble);
      end
    end
    display_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (anode_n !== exp_anode || nibble !== exp_nibble ||
          digit_idx !== 2'(exp_idx)) begin
        errors++;
        $display("FAIL en_resume i=%0d got %b/%h/%0d want %b/%h/%0d",
                 i, anode_n, nibble, digit_idx,
                 exp_anode, exp_nibble, exp_idx);
      end
      checks++;
      if ($countones(~anode_n) != 1) begin
        errors++;
        $display("FAIL en_onehot i=%0d got %b want one low", i, anode_n);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 4*DIV*ND; i++) begin
      if ((m_ticks / DIV) % ND == 2 && m_ticks % DIV == 1) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL mid_wait got timeout want digit 2");
    end
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if (digit_idx !== 2'd0 || anode_n !== 4'hF || nibble !== 4'h0) begin
      errors++;
      $display("FAIL mid_reset got %0d/%b/%h want 0/1111/0",
               digit_idx, anode_n, nibble);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checks++;
      if (nibble !== 4'h0 || anode_n !== exp_anode ||
          digit_idx !== 2'(exp_idx)) begin
        errors++;
        $display("FAIL mid_after i=%0d got %h/%b/%0d want 0/%b/%0d",
                 i, nibble, anode_n, digit_idx, exp_anode, exp_idx);
      end
    end
  endtask

  task automatic test_blank();
    logic [3:0] lit;
    logic [3:0] want;
    logic [15:0] vals [2];
    logic [3:0] wants [2];
    vals[0] = 16'h00A5;
    vals[1] = 16'h0000;
`ifdef LEADING_ZERO_BLANK_EN
    wants[0] = 4'b0011;
    wants[1] = 4'b0001;
`else
    wants[0] = 4'b1111;
    wants[1] = 4'b1111;
`endif
    for (int t = 0; t < 2; t++) begin
      load  = 1'b1;
      value = vals[t];
      @(negedge clk);
      load = 1'b0;
      repeat (2) @(negedge clk);
      lit  = 4'h0;
      want = wants[t];
      for (int i = 0; i < DIV*ND; i++) begin
        @(negedge clk);
        lit |= ~anode_n;
        checks++;
        if (nibble !== exp_nibble || anode_n !== exp_anode) begin
          errors++;
          $display("FAIL blank_model v=%h got %h/%b want %h/%b", vals[t],
                   nibble, anode_n, exp_nibble, exp_anode);
        end
      end
      checks++;
      if (lit !== want) begin
        errors++;
        $display("FAIL blank_lit v=%h got %b want %b", vals[t], lit, want);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      checks++;
      if (nibble !== exp_nibble || anode_n !== exp_anode ||
          digit_idx !== 2'(exp_idx)) begin
        errors++;
        $display("FAIL rand i=%0d got %h/%b/%0d want %h/%b/%0d",
                 i, nibble, anode_n, digit_idx,
                 exp_nibble, exp_anode, exp_idx);
      end
      load       = ($urandom % 4) == 0;
      value      = 16'($urandom);
      display_en = ($urandom % 8) != 0;
      reset_n    = ($urandom % 60) != 0;
    end
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_load_on_tc();
    test_display_en();
    test_reset_mid();
    test_blank();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
